// File: rtl/dcpu_intc_pkg.sv
// rtl/dcpu_intc_pkg.sv - shared constants, types and helpers for the dcpu interrupt controller
package dcpu_intc_pkg;

    // Register offsets within the 4-word window.
    localparam logic [1:0] REG_PEND   = 2'd0;
    localparam logic [1:0] REG_EN     = 2'd1;
    localparam logic [1:0] REG_ACTIVE = 2'd2;
    localparam logic [1:0] REG_MODE   = 2'd3;

    // Flag bit in the ACTIVE word marking "an enabled source is pending".
    localparam int ACTIVE_VALID = 15;

    // Per-source trigger mode.
    localparam logic MODE_EDGE  = 1'b0;
    localparam logic MODE_LEVEL = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_e;

    // Priority encoder: bit 0 wins. Scanning downward lets the lowest set
    // bit overwrite any higher one.
    function automatic logic [15:0] active_word(input logic [14:0] req);
        logic [15:0] res;
        res = 16'h0000;
        for (int i = 14; i >= 0; i--) begin
            if (req[i]) begin
                res               = 16'h0000;
                res[ACTIVE_VALID] = 1'b1;
                res[3:0]          = 4'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dcpu_intc_sync.sv
// rtl/dcpu_intc_sync.sv - two-flop synchronizer with rising-edge detect for one interrupt line
//   i_clk      clock
//   i_reset_n  asynchronous active-low reset
//   i_src      asynchronous request line
//   o_level    synchronized level
//   o_rise     one-cycle pulse on a synchronized rising edge
module dcpu_intc_sync (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_src,
    output logic o_level,
    output logic o_rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = i_src;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign o_level = sync2_q;
    assign o_rise  = sync2_q & ~prev_q;

endmodule

// File: rtl/dcpu_intc.sv
// rtl/dcpu_intc.sv - memory-mapped interrupt controller on the dcpu data bus
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   i_addr, i_dat      bus word address and write data
//   i_cs, i_we         bus chip select and write enable
//   o_dat, o_ack       read data and acknowledge, both 0 when not acking
//   i_src              asynchronous interrupt request lines
//   o_int              interrupt request to the CPU
module dcpu_intc
    import dcpu_intc_pkg::*;
#(
    parameter int          NUM_SRC   = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [15:0]        i_addr,
    input  logic [15:0]        i_dat,
    output logic [15:0]        o_dat,
    input  logic               i_cs,
    input  logic               i_we,
    output logic               o_ack,
    input  logic [NUM_SRC-1:0] i_src,
    output logic               o_int
);

    logic [NUM_SRC-1:0] src_level;
    logic [NUM_SRC-1:0] src_rise;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        dcpu_intc_sync u_sync (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_src     (i_src[g]),
            .o_level   (src_level[g]),
            .o_rise    (src_rise[g])
        );
    end

    bus_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] pend_q,  pend_d;
    logic [NUM_SRC-1:0] en_q,    en_d;
    logic [NUM_SRC-1:0] mode_q,  mode_d;
    logic [15:0]        dat_q,   dat_d;
    logic               int_q,   int_d;

    logic               sel;
    logic               acc_stb;
    logic               wr_stb;
    logic [NUM_SRC-1:0] wr_bits;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] req;
    logic [14:0]        req_wide;
    logic [15:0]        active;
    logic [15:0]        rd_dat;

    // Upper write-data bits have no register behind them.
    logic unused_dat;
    assign unused_dat = ^i_dat[15:NUM_SRC];

    always_comb begin
        sel      = i_cs && (i_addr[15:2] == BASE_ADDR[15:2]);
        // An access is taken only from IDLE, which spaces acks on a held cs.
        acc_stb  = (state_q == ST_IDLE) && sel;
        wr_stb   = acc_stb && i_we;
        wr_bits  = i_dat[NUM_SRC-1:0];

        req      = pend_q & en_q;
        req_wide = '0;
        req_wide[NUM_SRC-1:0] = req;
        active   = active_word(req_wide);

        rd_dat = 16'h0000;
        case (i_addr[1:0])
            REG_PEND:   rd_dat[NUM_SRC-1:0] = pend_q;
            REG_EN:     rd_dat[NUM_SRC-1:0] = en_q;
            REG_ACTIVE: rd_dat              = active;
            REG_MODE:   rd_dat[NUM_SRC-1:0] = mode_q;
            default:    rd_dat              = 16'h0000;
        endcase

        en_d   = en_q;
        mode_d = mode_q;
        if (wr_stb && (i_addr[1:0] == REG_EN))
            en_d = wr_bits;
        if (wr_stb && (i_addr[1:0] == REG_MODE))
            mode_d = wr_bits;

        w1c = (wr_stb && (i_addr[1:0] == REG_PEND)) ? wr_bits : '0;

        // Level sources mirror their input; edge sources latch, and a new
        // edge beats a simultaneous clear so no request is lost.
        pend_d = pend_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (mode_q[i] == MODE_LEVEL)
                pend_d[i] = src_level[i];
            else
                pend_d[i] = src_rise[i] | (pend_q[i] & ~w1c[i]);
        end

        int_d   = |req;
        state_d = acc_stb ? ST_ACK : ST_IDLE;
        // Read data is the pre-write value; zero whenever no ack follows.
        dat_d   = acc_stb ? rd_dat : 16'h0000;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            en_q    <= '0;
            mode_q  <= '0;
            dat_q   <= 16'h0000;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            en_q    <= en_d;
            mode_q  <= mode_d;
            dat_q   <= dat_d;
            int_q   <= int_d;
        end
    end

    assign o_ack = (state_q == ST_ACK);
    assign o_dat = dat_q;
    assign o_int = int_q;

endmodule

// File: tb/tb_dcpu_intc.sv
// tb/tb_dcpu_intc.sv - directed self-checking bench for dcpu_intc
module tb_dcpu_intc;

    localparam int          NUM_SRC = 8;
    localparam logic [15:0] BASE    = 16'hFF00;
    localparam logic [15:0] A_PEND  = BASE + 16'd0;
    localparam logic [15:0] A_EN    = BASE + 16'd1;
    localparam logic [15:0] A_ACT   = BASE + 16'd2;
    localparam logic [15:0] A_MODE  = BASE + 16'd3;

    logic               i_clk;
    logic               i_reset_n;
    logic [15:0]        i_addr;
    logic [15:0]        i_dat;
    logic [15:0]        o_dat;
    logic               i_cs;
    logic               i_we;
    logic               o_ack;
    logic [NUM_SRC-1:0] i_src;
    logic               o_int;

    int n_checks = 0;
    int n_fail   = 0;

    dcpu_intc #(.NUM_SRC(NUM_SRC), .BASE_ADDR(BASE)) u_dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_addr    (i_addr),
        .i_dat     (i_dat),
        .o_dat     (o_dat),
        .i_cs      (i_cs),
        .i_we      (i_we),
        .o_ack     (o_ack),
        .i_src     (i_src),
        .o_int     (o_int)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the bus idle.
    task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        i_cs = 1'b1; i_we = 1'b0; i_addr = addr; i_dat = 16'h0000;
        @(negedge i_clk);
        chk({tag, "_ack"}, 16'(o_ack), 16'h1);
        chk(tag, o_dat, exp);
        i_cs = 1'b0;
        @(negedge i_clk);
        chk({tag, "_ack_off"}, 16'(o_ack), 16'h0);
        chk({tag, "_dat_off"}, o_dat, 16'h0000);
    endtask

    task automatic wr(input string tag, input logic [15:0] addr, input logic [15:0] dat);
        i_cs = 1'b1; i_we = 1'b1; i_addr = addr; i_dat = dat;
        @(negedge i_clk);
        chk({tag, "_ack"}, 16'(o_ack), 16'h1);
        i_cs = 1'b0; i_we = 1'b0;
        @(negedge i_clk);
        chk({tag, "_ack_off"}, 16'(o_ack), 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        i_reset_n = 1'b0;
        i_cs = 1'b0; i_we = 1'b0; i_addr = 16'h0000; i_dat = 16'h0000; i_src = '0;
        #2;
        chk("rst_ack", 16'(o_ack), 16'h0);
        chk("rst_dat", o_dat, 16'h0000);
        chk("rst_int", 16'(o_int), 16'h0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);

        // Reset values of all registers.
        chk("pre_ack", 16'(o_ack), 16'h0);
        rd("rst_pend", A_PEND, 16'h0000);
        rd("rst_en",   A_EN,   16'h0000);
        rd("rst_act",  A_ACT,  16'h0000);
        rd("rst_mode", A_MODE, 16'h0000);
        chk("rst_int2", 16'(o_int), 16'h0);

        // Single-cycle pulse on source 2.
        wr("en4", A_EN, 16'h0004);
        i_src[2] = 1'b1;
        @(negedge i_clk);
        i_src[2] = 1'b0;
        k = 0;
        while (!o_int && k < 3) begin
            @(negedge i_clk);
            k++;
        end
        chk("int_rise", 16'(o_int), 16'h1);
        rd("pend4", A_PEND, 16'h0004);
        rd("act2",  A_ACT,  16'h8002);
        i_cs = 1'b1; i_we = 1'b1; i_addr = A_PEND; i_dat = 16'h0004;
        @(negedge i_clk);
        chk("w1c_ack", 16'(o_ack), 16'h1);
        chk("w1c_int_hold", 16'(o_int), 16'h1);
        i_cs = 1'b0; i_we = 1'b0;
        @(negedge i_clk);
        chk("w1c_int_off", 16'(o_int), 16'h0);
        rd("pend_clr", A_PEND, 16'h0000);

        // Priority between two sources.
        wr("enff", A_EN, 16'h00FF);
        i_src = 8'h28;
        repeat (4) @(negedge i_clk);
        rd("act3", A_ACT, 16'h8003);
        wr("clr3", A_PEND, 16'h0008);
        rd("act5", A_ACT, 16'h8005);
        i_src = 8'h00;
        wr("clr5", A_PEND, 16'h0020);
        rd("pend_zero", A_PEND, 16'h0000);
        rd("act_zero",  A_ACT,  16'h0000);

        // New edge lands on the same clock as a W1C of that bit.
        i_src[1] = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        wr("race_w1c", A_PEND, 16'h0002);
        rd("race_pend", A_PEND, 16'h0002);
        i_src[1] = 1'b0;
        wr("clr1", A_PEND, 16'h0002);
        rd("pend_zero2", A_PEND, 16'h0000);

        // Level mode on source 0.
        wr("mode1", A_MODE, 16'h0001);
        rd("mode_rb", A_MODE, 16'h0001);
        i_src[0] = 1'b1;
        repeat (4) @(negedge i_clk);
        rd("lvl_pend", A_PEND, 16'h0001);
        wr("lvl_w1c", A_PEND, 16'h0001);
        rd("lvl_keep", A_PEND, 16'h0001);
        i_src[0] = 1'b0;
        repeat (3) @(negedge i_clk);
        rd("lvl_drop", A_PEND, 16'h0000);
        wr("mode0", A_MODE, 16'h0000);

        // Unimplemented bits, read-only ACTIVE.
        wr("en_wide", A_EN, 16'hFFFF);
        rd("en_mask", A_EN, 16'h00FF);
        wr("act_wr", A_ACT, 16'hFFFF);
        rd("act_ro", A_ACT, 16'h0000);

        // Held chip select: ack, gap, ack, gap.
        i_cs = 1'b1; i_we = 1'b0; i_addr = A_EN;
        for (int j = 0; j < 4; j++) begin
            @(negedge i_clk);
            chk($sformatf("b2b_ack%0d", j), 16'(o_ack), (j % 2 == 0) ? 16'h1 : 16'h0);
            chk($sformatf("b2b_dat%0d", j), o_dat, (j % 2 == 0) ? 16'h00FF : 16'h0000);
        end
        i_cs = 1'b0;
        @(negedge i_clk);

        // Asynchronous reset during an ack.
        i_cs = 1'b1; i_we = 1'b1; i_addr = A_EN; i_dat = 16'h000F;
        @(posedge i_clk);
        #1;
        chk("mid_ack", 16'(o_ack), 16'h1);
        i_reset_n = 1'b0;
        #1;
        chk("mid_ack_drop", 16'(o_ack), 16'h0);
        chk("mid_dat_drop", o_dat, 16'h0000);
        i_cs = 1'b0; i_we = 1'b0;
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        rd("en_after_rst", A_EN, 16'h0000);

        // Accesses outside the map.
        wr("en_f", A_EN, 16'h000F);
        i_cs = 1'b1; i_we = 1'b1; i_addr = BASE + 16'd4; i_dat = 16'h0000;
        for (int j = 0; j < 3; j++) begin
            @(negedge i_clk);
            chk($sformatf("oom_ack%0d", j), 16'(o_ack), 16'h0);
            chk($sformatf("oom_dat%0d", j), o_dat, 16'h0000);
        end
        i_addr = 16'hFE01;
        @(negedge i_clk);
        chk("oom2_ack", 16'(o_ack), 16'h0);
        i_cs = 1'b0; i_we = 1'b0;
        @(negedge i_clk);
        rd("en_kept", A_EN, 16'h000F);
        chk("final_int", 16'(o_int), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
